seg7_digit_scanner: RTL
=======================

// Module: seg7_digit_scanner
// PURPOSE
//  Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
//  - Holds a DIGITS-nibble display word.
//  - Each slot, presents one nibble on hex[3:0] to the downstream hexToSeg7 decoder.
//  - Drives the matching active-low digit enable.
//  - Anti-ghost guard interval between slots; word updates take effect only at a frame boundary (no tearing).
// PARAMETERS
//  DIGITS    4      number of digits, legal 1..8
//  PRESCALE  50000  clk cycles per digit slot, legal >= GUARD+1
//  GUARD     16     cycles at start of each slot with all digits off, legal 0..PRESCALE-1
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst_n      in   1         synchronous active-low reset
//  value      in   4*DIGITS  display word; nibble i = value[4i+3:4i] shown on digit i
//  load       in   1         capture value into pending register this cycle
//  blankMask  in   DIGITS    bit i=1: digit i is never enabled (leading-zero blanking)
//  hex        out  4         nibble for current slot -> hexToSeg7.hex
//  digitEnN   out  DIGITS    active-low digit enables, at most one bit low at any time
//  digitIdx   out  $clog2(DIGITS) (min 1)  index of current slot
//  frameTick  out  1         one-cycle pulse on first cycle of slot 0
// BEHAVIOUR
//  - State:
//    - cnt: slot counter, 0..PRESCALE-1
//    - idx: digit counter, 0..DIGITS-1
//    - pending, active: 4*DIGITS each
//    - pendValid: 1
//  - Reset (rst_n=0 at edge): all counters, pending, active and pendValid are 0.
//    - Outputs: hex=0, digitIdx=0, digitEnN=all 1s, frameTick=0.
//    - Reset mid-slot aborts the scan immediately; no enable stays low.
//  - First active edge after reset release: cnt=0, idx=0, frameTick=1; new active = 0 unless load was high that cycle.
//  - Counting, each edge:
//    - cnt<PRESCALE-1: cnt++.
//    - Otherwise cnt=0 and idx advances; idx wraps DIGITS-1 -> 0.
//  - Frame boundary = the edge where idx goes DIGITS-1 -> 0 (and the post-reset first edge).
//  - All outputs are registered and computed from the post-edge cnt/idx/active values, so they are consistent in the same cycle:
//    - digitIdx = idx
//    - hex = active[4*idx+:4]
//    - digitEnN[idx] = 0 iff cnt >= GUARD and blankMask[idx]==0; all other bits 1.
//    - frameTick = 1 iff idx==0 and cnt==0.
//  - blankMask is sampled every cycle; a change takes effect on the next edge, mid-slot included.
//  - Load/update:
//    - load=1: pending<=value, pendValid<=1.
//    - At a frame boundary with pendValid=1: active<=pending, pendValid<=0.
//  - Simultaneous load and frame boundary: active<=value directly (newest wins); pendValid<=0.
//  - Multiple loads within one frame: last one wins.
//  - DIGITS=1: idx is constant 0; every slot end is a frame boundary.
//  - GUARD=0: the enable is low for the entire slot.
//  - Latency: a load is visible on hex at the next frame start, at most DIGITS*PRESCALE cycles later.
// TESTING
//  Params: DIGITS=4, PRESCALE=4, GUARD=1 unless noted.
//  1. Reset sequence: hold rst_n=0 3 cycles -> digitEnN=4'b1111, hex=0, frameTick=0. Release -> frameTick=1 on the 1st cycle; digitEnN=4'b1111 on the 1st cycle, 4'b1110 on cycles 2-4.
//  2. Scan order: after reset, load value=16'h4321 -> shown from the next frame.
//     - Slots show hex 1,2,3,4 with digitEnN 1110,1101,1011,0111 on slot cycles 1..3.
//     - All 1s on slot cycle 0.
//     - frameTick period = 16 cycles.
//  3. No tearing: load 16'hABCD while idx=2 mid-frame -> digits 2,3 still show the old word. At the next frameTick, hex=D, then C,B,A.
//  4. Simultaneous edge: load 16'h1111 then 16'h2222 in the same frame, the second on the cycle before the boundary edge -> next frame shows 2,2,2,2.
//  5. Blanking: blankMask=4'b1000, value=16'h0123 -> digit 3 enable stays 1 all frame; digits 0-2 scan normally; hex in slot 3 is still 0.
//  6. Reset mid-slot: assert rst_n=0 while digitEnN=4'b1011 -> next cycle digitEnN=4'b1111, hex=0. After release, active=0 until a new load is applied at a frame boundary.
//     - GUARD=0 variant: enable is low for all 4 slot cycles.

Source files
------------

// File: rtl/seg7_digit_scanner.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. Presents one nibble per slot to a downstream hex decoder, drives
// the matching active-low digit enable after an anti-ghost guard interval,
// and swaps in a newly loaded display word only at frame boundaries.
module seg7_digit_scanner #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GUARD    = 16,
  localparam int unsigned IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blankMask,
  output logic [3:0]            hex,
  output logic [DIGITS-1:0]     digitEnN,
  output logic [IW-1:0]         digitIdx,
  output logic                  frameTick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // ST_START is the single cycle following reset: the next edge is a frame
  // boundary that lands on cnt=0/idx=0 instead of counting forward.
  typedef enum logic {
    ST_START,
    ST_SCAN
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  frame_edge;
  logic [4*DIGITS-1:0]   pending, pending_n;
  logic [4*DIGITS-1:0]   active, active_n;
  logic                  pend_valid, pend_valid_n;
  logic [3:0]            hex_n;
  logic [DIGITS-1:0]     en_n;
  logic                  tick_n;

  // Slot/digit counter advance and frame boundary detection.
  always_comb begin
    state_n    = ST_SCAN;
    cnt_n      = '0;
    idx_n      = '0;
    frame_edge = 1'b0;
    case (state)
      ST_START: frame_edge = 1'b1;
      default: begin
        if (cnt != CW'(PRESCALE - 1)) begin
          cnt_n = cnt + CW'(1);
          idx_n = idx;
        end else if (idx == IW'(DIGITS - 1)) begin
          frame_edge = 1'b1;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
    endcase
  end

  // Word staging: a load coinciding with a boundary bypasses pending so the
  // newest word wins; otherwise pending is promoted at the boundary.
  always_comb begin
    pending_n    = pending;
    pend_valid_n = pend_valid;
    active_n     = active;
    if (frame_edge && load) begin
      active_n     = value;
      pending_n    = value;
      pend_valid_n = 1'b0;
    end else begin
      if (frame_edge && pend_valid) begin
        active_n     = pending;
        pend_valid_n = 1'b0;
      end
      if (load) begin
        pending_n    = value;
        pend_valid_n = 1'b1;
      end
    end
  end

  // Outputs derived from the post-edge counter and word so they agree in-cycle.
  always_comb begin
    en_n  = '1;
    hex_n = active_n[4*idx_n +: 4];
    if ((cnt_n >= CW'(GUARD)) && !blankMask[idx_n]) begin
      en_n[idx_n] = 1'b0;
    end
    tick_n = (idx_n == '0) && (cnt_n == '0);
  end

  // State, staging and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_START;
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      active     <= '0;
      pend_valid <= 1'b0;
      hex        <= '0;
      digitEnN   <= '1;
      digitIdx   <= '0;
      frameTick  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      pending    <= pending_n;
      active     <= active_n;
      pend_valid <= pend_valid_n;
      hex        <= hex_n;
      digitEnN   <= en_n;
      digitIdx   <= idx_n;
      frameTick  <= tick_n;
    end
  end

endmodule
